// File: rtl/pipe_split_ctrl_pkg.sv
// Shared widths and the stage-2 control bundle for the
// execute/memory split of the pipeline.
package pipe_split_ctrl_pkg;

    localparam int DBITS_DEF = 32;
    localparam int REG_INDEX_BIT_WIDTH_DEF = 4;

    typedef struct packed {
        logic valid;
        logic memtoReg;
        logic memWrite;
        logic jal;
        logic regWrite;
    } m_flags_t;

    localparam m_flags_t M_FLAGS_BUBBLE = '0;

endpackage

// File: rtl/pipe_split_ctrl_hazard_detect.sv
// RAW hazard detection against the stage-2 instruction:
// forward ALU/link results or stall on a load-use.
module hazard_detect
    import pipe_split_ctrl_pkg::*;
#(
    parameter int DBITS = DBITS_DEF,
    parameter int REG_INDEX_BIT_WIDTH = REG_INDEX_BIT_WIDTH_DEF,
    parameter bit FORWARD_EN = 1'b1
) (
    input  m_flags_t                       m_flags,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] m_dr,
    input  logic [DBITS-1:0]               m_aluOut,
    input  logic [DBITS-1:0]               m_incPC,
    input  logic                           x_valid,
    input  logic                           x_use1,
    input  logic                           x_use2,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] x_sr1,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] x_sr2,
    output logic                           stall,
    output logic                           fwd1,
    output logic                           fwd2,
    output logic [DBITS-1:0]               fwd_data
);

    logic producer;
    logic hit1;
    logic hit2;

    assign producer = m_flags.valid & m_flags.regWrite & x_valid;
    assign hit1 = producer & x_use1 & (m_dr == x_sr1);
    assign hit2 = producer & x_use2 & (m_dr == x_sr2);

    // A load result is not available until after stage 2.
    always_comb begin
        stall = 1'b0;
        fwd1 = 1'b0;
        fwd2 = 1'b0;
        if (FORWARD_EN) begin
            stall = (hit1 | hit2) & m_flags.memtoReg;
            fwd1 = hit1 & ~m_flags.memtoReg;
            fwd2 = hit2 & ~m_flags.memtoReg;
        end else begin
            stall = hit1 | hit2;
        end
    end

    assign fwd_data = m_flags.jal ? m_incPC : m_aluOut;

endmodule

// File: rtl/pipe_split_ctrl.sv
// Execute-to-memory stage register with hazard control and
// saturating retired/stall performance counters.
module pipe_split_ctrl
    import pipe_split_ctrl_pkg::*;
#(
    parameter int DBITS = DBITS_DEF,
    parameter int REG_INDEX_BIT_WIDTH = REG_INDEX_BIT_WIDTH_DEF,
    parameter bit FORWARD_EN = 1'b1,
    parameter int CNT_BITS = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           x_valid,
    input  logic                           x_memtoReg,
    input  logic                           x_memWrite,
    input  logic                           x_jal,
    input  logic                           x_regWrite,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] x_dr,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] x_sr1,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] x_sr2,
    input  logic                           x_use1,
    input  logic                           x_use2,
    input  logic [DBITS-1:0]               x_aluOut,
    input  logic [DBITS-1:0]               x_sr2Out,
    input  logic [DBITS-1:0]               x_incPC,
    input  logic                           flush,
    input  logic                           cnt_clr,
    output logic                           m_valid,
    output logic                           m_memtoReg,
    output logic                           m_memWrite,
    output logic                           m_jal,
    output logic                           m_regWrite,
    output logic [REG_INDEX_BIT_WIDTH-1:0] m_dr,
    output logic [DBITS-1:0]               m_aluOut,
    output logic [DBITS-1:0]               m_sr2Out,
    output logic [DBITS-1:0]               m_incPC,
    output logic                           stall,
    output logic                           fwd1,
    output logic                           fwd2,
    output logic [DBITS-1:0]               fwd_data,
    output logic [CNT_BITS-1:0]            retired_cnt,
    output logic [CNT_BITS-1:0]            stall_cnt
);

    m_flags_t m_flags;
    logic     advance;

    assign m_valid    = m_flags.valid;
    assign m_memtoReg = m_flags.memtoReg;
    assign m_memWrite = m_flags.memWrite;
    assign m_jal      = m_flags.jal;
    assign m_regWrite = m_flags.regWrite;

    // Flush beats stall: either way stage 2 receives a bubble.
    assign advance = x_valid & ~stall & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_flags  <= M_FLAGS_BUBBLE;
            m_dr     <= '0;
            m_aluOut <= '0;
            m_sr2Out <= '0;
            m_incPC  <= '0;
        end else begin
            m_flags.valid    <= advance;
            m_flags.memtoReg <= x_memtoReg;
            m_flags.memWrite <= x_memWrite & advance;
            m_flags.jal      <= x_jal;
            m_flags.regWrite <= x_regWrite & advance;
            m_dr             <= x_dr;
            m_aluOut         <= x_aluOut;
            m_sr2Out         <= x_sr2Out;
            m_incPC          <= x_incPC;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else if (cnt_clr) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (m_flags.valid && retired_cnt != '1)
                retired_cnt <= retired_cnt + 1'b1;
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    hazard_detect #(
        .DBITS              (DBITS),
        .REG_INDEX_BIT_WIDTH(REG_INDEX_BIT_WIDTH),
        .FORWARD_EN         (FORWARD_EN)
    ) u_hazard (
        .m_flags (m_flags),
        .m_dr    (m_dr),
        .m_aluOut(m_aluOut),
        .m_incPC (m_incPC),
        .x_valid (x_valid),
        .x_use1  (x_use1),
        .x_use2  (x_use2),
        .x_sr1   (x_sr1),
        .x_sr2   (x_sr2),
        .stall   (stall),
        .fwd1    (fwd1),
        .fwd2    (fwd2),
        .fwd_data(fwd_data)
    );

endmodule

// File: tb/tb_pipe_split_ctrl.sv
// Directed bench: forwarding instance (a) and stall-only
// instance (b, 4-bit counters) share one stimulus stream.
module tb_pipe_split_ctrl;

    logic        clk;
    logic        reset;
    logic        x_valid, x_memtoReg, x_memWrite, x_jal, x_regWrite;
    logic [3:0]  x_dr, x_sr1, x_sr2;
    logic        x_use1, x_use2;
    logic [31:0] x_aluOut, x_sr2Out, x_incPC;
    logic        flush, cnt_clr;

    logic        m_valid, m_memtoReg, m_memWrite, m_jal, m_regWrite;
    logic [3:0]  m_dr;
    logic [31:0] m_aluOut, m_sr2Out, m_incPC;
    logic        stall, fwd1, fwd2;
    logic [31:0] fwd_data;
    logic [15:0] retired_cnt, stall_cnt;

    logic        b_valid, b_memtoReg, b_memWrite, b_jal, b_regWrite;
    logic [3:0]  b_dr;
    logic [31:0] b_aluOut, b_sr2Out, b_incPC;
    logic        b_stall, b_fwd1, b_fwd2;
    logic [31:0] b_fwd_data;
    logic [3:0]  b_retired, b_stall_cnt;

    int errors = 0;
    int checks = 0;

    pipe_split_ctrl #(
        .DBITS(32), .REG_INDEX_BIT_WIDTH(4),
        .FORWARD_EN(1'b1), .CNT_BITS(16)
    ) dut_a (
        .clk(clk), .reset(reset),
        .x_valid(x_valid), .x_memtoReg(x_memtoReg),
        .x_memWrite(x_memWrite), .x_jal(x_jal),
        .x_regWrite(x_regWrite), .x_dr(x_dr),
        .x_sr1(x_sr1), .x_sr2(x_sr2),
        .x_use1(x_use1), .x_use2(x_use2),
        .x_aluOut(x_aluOut), .x_sr2Out(x_sr2Out),
        .x_incPC(x_incPC), .flush(flush), .cnt_clr(cnt_clr),
        .m_valid(m_valid), .m_memtoReg(m_memtoReg),
        .m_memWrite(m_memWrite), .m_jal(m_jal),
        .m_regWrite(m_regWrite), .m_dr(m_dr),
        .m_aluOut(m_aluOut), .m_sr2Out(m_sr2Out),
        .m_incPC(m_incPC), .stall(stall),
        .fwd1(fwd1), .fwd2(fwd2), .fwd_data(fwd_data),
        .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
    );

    pipe_split_ctrl #(
        .DBITS(32), .REG_INDEX_BIT_WIDTH(4),
        .FORWARD_EN(1'b0), .CNT_BITS(4)
    ) dut_b (
        .clk(clk), .reset(reset),
        .x_valid(x_valid), .x_memtoReg(x_memtoReg),
        .x_memWrite(x_memWrite), .x_jal(x_jal),
        .x_regWrite(x_regWrite), .x_dr(x_dr),
        .x_sr1(x_sr1), .x_sr2(x_sr2),
        .x_use1(x_use1), .x_use2(x_use2),
        .x_aluOut(x_aluOut), .x_sr2Out(x_sr2Out),
        .x_incPC(x_incPC), .flush(flush), .cnt_clr(cnt_clr),
        .m_valid(b_valid), .m_memtoReg(b_memtoReg),
        .m_memWrite(b_memWrite), .m_jal(b_jal),
        .m_regWrite(b_regWrite), .m_dr(b_dr),
        .m_aluOut(b_aluOut), .m_sr2Out(b_sr2Out),
        .m_incPC(b_incPC), .stall(b_stall),
        .fwd1(b_fwd1), .fwd2(b_fwd2), .fwd_data(b_fwd_data),
        .retired_cnt(b_retired), .stall_cnt(b_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xset(input logic v, input logic mtr, input logic mw,
                        input logic jl, input logic rw,
                        input logic [3:0] dr, input logic [3:0] s1,
                        input logic [3:0] s2, input logic u1,
                        input logic u2, input logic [31:0] alu,
                        input logic [31:0] inc);
        x_valid = v; x_memtoReg = mtr; x_memWrite = mw;
        x_jal = jl; x_regWrite = rw; x_dr = dr;
        x_sr1 = s1; x_sr2 = s2; x_use1 = u1; x_use2 = u2;
        x_aluOut = alu; x_sr2Out = ~alu; x_incPC = inc;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        xset(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_dr", 32'(m_dr), 32'd0);
        chk("rst_m_aluOut", m_aluOut, 32'd0);
        chk("rst_retired", 32'(retired_cnt), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        tick();
        reset = 1'b1;

        // ADD r3 then ADD r4 = r3 + r2
        xset(1, 0, 0, 0, 1, 3, 1, 2, 1, 1, 32'h10, 32'h4);
        #1;
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_fwd1", 32'(fwd1), 32'd0);
        tick();
        chk("add_m_valid", 32'(m_valid), 32'd1);
        chk("add_m_dr", 32'(m_dr), 32'd3);
        chk("add_m_sr2Out", m_sr2Out, 32'hFFFF_FFEF);
        xset(1, 0, 0, 0, 1, 4, 3, 2, 1, 1, 32'h20, 32'h8);
        #1;
        chk("fwd_fwd1", 32'(fwd1), 32'd1);
        chk("fwd_fwd2", 32'(fwd2), 32'd0);
        chk("fwd_data", fwd_data, 32'h10);
        chk("fwd_stall", 32'(stall), 32'd0);
        chk("nofwd_stall", 32'(b_stall), 32'd1);
        chk("nofwd_fwd1", 32'(b_fwd1), 32'd0);
        tick();
        chk("fwd_next_alu", m_aluOut, 32'h20);
        chk("fwd_retired", 32'(retired_cnt), 32'd1);
        chk("nofwd_bubble", 32'(b_valid), 32'd0);
        chk("nofwd_bubble_rw", 32'(b_regWrite), 32'd0);
        chk("nofwd_stall_cnt", 32'(b_stall_cnt), 32'd1);
        chk("nofwd_stall_gone", 32'(b_stall), 32'd0);

        // LW r5 with counter clear, then ADD r6 reading r5 on sr2
        cnt_clr = 1'b1;
        xset(1, 1, 0, 0, 1, 5, 0, 0, 0, 0, 32'h100, 32'hC);
        tick();
        cnt_clr = 1'b0;
        chk("clr_prio_retired", 32'(retired_cnt), 32'd0);
        xset(1, 0, 0, 0, 1, 6, 1, 5, 1, 1, 32'h55, 32'h10);
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_fwd2", 32'(fwd2), 32'd0);
        tick();
        chk("lu_bubble", 32'(m_valid), 32'd0);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        chk("lu_stall_clear", 32'(stall), 32'd0);
        tick();
        chk("lu_add_valid", 32'(m_valid), 32'd1);
        chk("lu_add_alu", m_aluOut, 32'h55);
        xset(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("lu_retired", 32'(retired_cnt), 32'd2);
        chk("lu_stall_cnt2", 32'(stall_cnt), 32'd1);

        // JAL r15 then reader of r15 on sr2 only
        xset(1, 0, 0, 1, 1, 15, 0, 0, 0, 0, 32'h99, 32'h24);
        tick();
        xset(1, 0, 0, 0, 1, 2, 15, 15, 0, 1, 32'h1, 32'h28);
        #1;
        chk("jal_fwd2", 32'(fwd2), 32'd1);
        chk("jal_fwd1_unused", 32'(fwd1), 32'd0);
        chk("jal_fwd_data", fwd_data, 32'h24);

        // load-use with a simultaneous flush
        xset(1, 1, 0, 0, 1, 7, 0, 0, 0, 0, 32'h200, 32'h2C);
        tick();
        xset(1, 0, 0, 0, 1, 8, 7, 0, 1, 0, 32'h3, 32'h30);
        flush = 1'b1;
        #1;
        chk("fs_stall", 32'(stall), 32'd1);
        tick();
        chk("fs_bubble", 32'(m_valid), 32'd0);
        chk("fs_stall_cnt", 32'(stall_cnt), 32'd2);

        // SW squashed by flush
        xset(1, 0, 1, 0, 0, 0, 1, 2, 1, 1, 32'h40, 32'h34);
        tick();
        chk("sw_flush_valid", 32'(m_valid), 32'd0);
        chk("sw_flush_mw", 32'(m_memWrite), 32'd0);
        flush = 1'b0;
        tick();
        chk("sw_mw", 32'(m_memWrite), 32'd1);

        // r0 forwards like any register
        xset(1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 32'h7, 32'h38);
        tick();
        xset(1, 0, 0, 0, 1, 9, 0, 1, 1, 0, 32'h8, 32'h3C);
        #1;
        chk("r0_fwd1", 32'(fwd1), 32'd1);
        chk("r0_fwd_data", fwd_data, 32'h7);

        // saturation of the 4-bit counters
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_b_stall", 32'(b_stall_cnt), 32'd0);
        chk("clr_b_retired", 32'(b_retired), 32'd0);
        xset(1, 0, 0, 0, 1, 1, 1, 0, 1, 0, 32'h11, 32'h40);
        repeat (40) tick();
        chk("sat_b_stall", 32'(b_stall_cnt), 32'hF);
        chk("sat_b_retired", 32'(b_retired), 32'hF);
        chk("sat_a_stall", 32'(stall_cnt), 32'd0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("sat_clr_stall", 32'(b_stall_cnt), 32'd0);
        chk("sat_clr_retired", 32'(b_retired), 32'd0);

        // reset during a load-use stall
        xset(1, 1, 0, 0, 1, 5, 0, 0, 0, 0, 32'h300, 32'h44);
        tick();
        xset(1, 0, 0, 0, 1, 6, 5, 0, 1, 0, 32'h4, 32'h48);
        #1;
        chk("mid_stall", 32'(stall), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_alu", m_aluOut, 32'd0);
        chk("mid_rst_retired", 32'(retired_cnt), 32'd0);
        tick();
        chk("in_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("in_rst_retired", 32'(retired_cnt), 32'd0);
        chk("in_rst_valid", 32'(m_valid), 32'd0);
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
